// File: rtl/fm_3d_mem_arb.sv
`default_nettype none
// ============================================================================
// Module      : fm_3d_mem_arb
// Description : Two-port burst arbiter onto one memory master port, with a
//               read-return timeout and a sticky error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module fm_3d_mem_arb #(
    parameter int P_FIXED_PRI = 0,
    parameter int P_RD_TOUT   = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    // port 0
    input  logic        i_req_p0,
    input  logic        i_wr_p0,
    input  logic [31:0] i_adrs_p0,
    input  logic [2:0]  i_len_p0,
    input  logic [3:0]  i_be_p0,
    input  logic [31:0] i_dbw_p0,
    output logic        o_ack_p0,
    output logic        o_strr_p0,
    output logic [31:0] o_dbr_p0,
    // port 1
    input  logic        i_req_p1,
    input  logic        i_wr_p1,
    input  logic [31:0] i_adrs_p1,
    input  logic [2:0]  i_len_p1,
    input  logic [3:0]  i_be_p1,
    input  logic [31:0] i_dbw_p1,
    output logic        o_ack_p1,
    output logic        o_strr_p1,
    output logic [31:0] o_dbr_p1,
    // master
    output logic        o_req_m,
    output logic        o_wr_m,
    output logic [31:0] o_adrs_m,
    output logic [2:0]  o_len_m,
    output logic [3:0]  o_be_m,
    output logic [31:0] o_dbw_m,
    input  logic        i_ack_m,
    input  logic        i_strr_m,
    input  logic [31:0] i_dbr_m,
    // status
    output logic [1:0]  o_gnt,
    output logic        o_err
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WRITE     = 2'd1;
    localparam logic [1:0] ST_READ      = 2'd2;
    localparam logic [1:0] ST_READ_WAIT = 2'd3;
    localparam logic [7:0] TOUT_LAST    = 8'(P_RD_TOUT - 1);

    logic [1:0] state,    state_nx;
    logic [1:0] gnt,      gnt_nx;
    logic       last_gnt, last_gnt_nx;   // index of the port that finished last
    logic [2:0] len,      len_nx;
    logic [2:0] cnt,      cnt_nx;
    logic [7:0] tout,     tout_nx;
    logic       err,      err_nx;

    logic       cur_port;
    logic       cur_req;

    assign cur_port = gnt[1];
    assign cur_req  = cur_port ? i_req_p1 : i_req_p0;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= ST_IDLE;
            gnt      <= 2'b00;
            last_gnt <= 1'b1;
            len      <= 3'd0;
            cnt      <= 3'd0;
            tout     <= 8'd0;
            err      <= 1'b0;
        end else begin
            state    <= state_nx;
            gnt      <= gnt_nx;
            last_gnt <= last_gnt_nx;
            len      <= len_nx;
            cnt      <= cnt_nx;
            tout     <= tout_nx;
            err      <= err_nx;
        end
    end

    always_comb begin
        logic pick1;
        logic wr_sel;
        state_nx    = state;
        gnt_nx      = gnt;
        last_gnt_nx = last_gnt;
        len_nx      = len;
        cnt_nx      = cnt;
        tout_nx     = tout;
        err_nx      = err;
        pick1       = 1'b0;
        wr_sel      = 1'b0;

        // A strobe with no read outstanding means the return path is confused.
        if (i_strr_m && (state != ST_READ_WAIT))
            err_nx = 1'b1;

        case (state)
            ST_IDLE: begin
                if (i_req_p0 || i_req_p1) begin
                    if (i_req_p0 && i_req_p1)
                        pick1 = (P_FIXED_PRI != 0) ? 1'b0 : ~last_gnt;
                    else
                        pick1 = i_req_p1;
                    wr_sel   = pick1 ? i_wr_p1  : i_wr_p0;
                    len_nx   = pick1 ? i_len_p1 : i_len_p0;
                    gnt_nx   = pick1 ? 2'b10 : 2'b01;
                    cnt_nx   = 3'd0;
                    state_nx = wr_sel ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                if ((cnt == 3'd0) && !cur_req) begin
                    state_nx = ST_IDLE;
                    gnt_nx   = 2'b00;
                end else if (i_ack_m) begin
                    if (cnt == len) begin
                        state_nx    = ST_IDLE;
                        gnt_nx      = 2'b00;
                        last_gnt_nx = cur_port;
                    end else begin
                        cnt_nx = cnt + 3'd1;
                    end
                end
            end
            ST_READ: begin
                if (!cur_req) begin
                    state_nx = ST_IDLE;
                    gnt_nx   = 2'b00;
                end else if (i_ack_m) begin
                    state_nx = ST_READ_WAIT;
                    cnt_nx   = 3'd0;
                    tout_nx  = 8'd0;
                end
            end
            default: begin
                if (i_strr_m) begin
                    tout_nx = 8'd0;
                    if (cnt == len) begin
                        state_nx    = ST_IDLE;
                        gnt_nx      = 2'b00;
                        last_gnt_nx = cur_port;
                    end else begin
                        cnt_nx = cnt + 3'd1;
                    end
                end else if (tout == TOUT_LAST) begin
                    err_nx      = 1'b1;
                    state_nx    = ST_IDLE;
                    gnt_nx      = 2'b00;
                    last_gnt_nx = cur_port;
                end else begin
                    tout_nx = tout + 8'd1;
                end
            end
        endcase
    end

    always_comb begin
        o_req_m   = 1'b0;
        o_wr_m    = 1'b0;
        o_adrs_m  = 32'd0;
        o_len_m   = 3'd0;
        o_be_m    = 4'd0;
        o_dbw_m   = 32'd0;
        o_strr_p0 = 1'b0;
        o_strr_p1 = 1'b0;
        o_dbr_p0  = 32'd0;
        o_dbr_p1  = 32'd0;
        if (gnt != 2'b00) begin
            // The command has already been accepted once we wait for data.
            o_req_m  = (state == ST_READ_WAIT) ? 1'b0 : cur_req;
            o_wr_m   = cur_port ? i_wr_p1   : i_wr_p0;
            o_adrs_m = cur_port ? i_adrs_p1 : i_adrs_p0;
            o_len_m  = cur_port ? i_len_p1  : i_len_p0;
            o_be_m   = cur_port ? i_be_p1   : i_be_p0;
            o_dbw_m  = cur_port ? i_dbw_p1  : i_dbw_p0;
        end
        if (state == ST_READ_WAIT) begin
            o_strr_p0 = i_strr_m & gnt[0];
            o_strr_p1 = i_strr_m & gnt[1];
            o_dbr_p0  = gnt[0] ? i_dbr_m : 32'd0;
            o_dbr_p1  = gnt[1] ? i_dbr_m : 32'd0;
        end
    end

    assign o_ack_p0 = i_ack_m & gnt[0];
    assign o_ack_p1 = i_ack_m & gnt[1];
    assign o_gnt    = gnt;
    assign o_err    = err;

endmodule
`default_nettype wire

// File: tb/tb_fm_3d_mem_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_fm_3d_mem_arb
// Description : Scoreboard bench for fm_3d_mem_arb (round-robin and fixed).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fm_3d_mem_arb;

    localparam logic K_ACK  = 1'b0;
    localparam logic K_STRR = 1'b1;

    typedef struct packed {
        logic        port;
        logic        kind;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, wr0, req1, wr1;
    logic [31:0] adrs0, dbw0, adrs1, dbw1;
    logic [2:0]  len0, len1;
    logic [3:0]  be0, be1;
    logic        ack_m, strr_m, auto_ack;
    logic [31:0] dbr_m;
    logic        fx_req0, fx_req1;

    logic        ack_p0, strr_p0, ack_p1, strr_p1;
    logic [31:0] dbr_p0, dbr_p1;
    logic        m_req, m_wr;
    logic [31:0] m_adrs, m_dbw;
    logic [2:0]  m_len;
    logic [3:0]  m_be;
    logic [1:0]  gnt;
    logic        err;
    logic        ack_in;

    logic        fx_ack_p0, fx_strr_p0, fx_ack_p1, fx_strr_p1;
    logic [31:0] fx_dbr_p0, fx_dbr_p1;
    logic        fx_m_req, fx_m_wr;
    logic [31:0] fx_m_adrs, fx_m_dbw;
    logic [2:0]  fx_m_len;
    logic [3:0]  fx_m_be;
    logic [1:0]  fx_gnt;
    logic        fx_err;
    logic        fx_ack_in;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    // Memory side answers every command immediately when auto_ack is set.
    assign ack_in    = ack_m | (auto_ack & m_req);
    assign fx_ack_in = auto_ack & fx_m_req;

    always #5 clk = ~clk;

    fm_3d_mem_arb #(.P_FIXED_PRI(0), .P_RD_TOUT(16)) u_dut (
        .clk_i(clk), .rst_i(rst_n),
        .i_req_p0(req0), .i_wr_p0(wr0), .i_adrs_p0(adrs0), .i_len_p0(len0),
        .i_be_p0(be0), .i_dbw_p0(dbw0),
        .o_ack_p0(ack_p0), .o_strr_p0(strr_p0), .o_dbr_p0(dbr_p0),
        .i_req_p1(req1), .i_wr_p1(wr1), .i_adrs_p1(adrs1), .i_len_p1(len1),
        .i_be_p1(be1), .i_dbw_p1(dbw1),
        .o_ack_p1(ack_p1), .o_strr_p1(strr_p1), .o_dbr_p1(dbr_p1),
        .o_req_m(m_req), .o_wr_m(m_wr), .o_adrs_m(m_adrs), .o_len_m(m_len),
        .o_be_m(m_be), .o_dbw_m(m_dbw),
        .i_ack_m(ack_in), .i_strr_m(strr_m), .i_dbr_m(dbr_m),
        .o_gnt(gnt), .o_err(err)
    );

    fm_3d_mem_arb #(.P_FIXED_PRI(1), .P_RD_TOUT(16)) u_fix (
        .clk_i(clk), .rst_i(rst_n),
        .i_req_p0(fx_req0), .i_wr_p0(wr0), .i_adrs_p0(adrs0), .i_len_p0(len0),
        .i_be_p0(be0), .i_dbw_p0(dbw0),
        .o_ack_p0(fx_ack_p0), .o_strr_p0(fx_strr_p0), .o_dbr_p0(fx_dbr_p0),
        .i_req_p1(fx_req1), .i_wr_p1(wr1), .i_adrs_p1(adrs1), .i_len_p1(len1),
        .i_be_p1(be1), .i_dbw_p1(dbw1),
        .o_ack_p1(fx_ack_p1), .o_strr_p1(fx_strr_p1), .o_dbr_p1(fx_dbr_p1),
        .o_req_m(fx_m_req), .o_wr_m(fx_m_wr), .o_adrs_m(fx_m_adrs), .o_len_m(fx_m_len),
        .o_be_m(fx_m_be), .o_dbw_m(fx_m_dbw),
        .i_ack_m(fx_ack_in), .i_strr_m(1'b0), .i_dbr_m(32'd0),
        .o_gnt(fx_gnt), .o_err(fx_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic port, input logic kind, input logic [31:0] data);
        exp_t e;
        e.port = port;
        e.kind = kind;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic sb_check(input logic port, input logic kind, input logic [31:0] data);
        exp_t e;
        tests = tests + 1;
        if (sb.size() == 0) begin
            fails = fails + 1;
            $display("FAIL sb_unexpected: port %0d kind %0d data %h, queue empty at %0t",
                     port, kind, data, $time);
        end else begin
            e = sb.pop_front();
            if (e.port !== port || e.kind !== kind || e.data !== data) begin
                fails = fails + 1;
                $display("FAIL sb_event: got port %0d kind %0d data %h, expected port %0d kind %0d data %h at %0t",
                         port, kind, data, e.port, e.kind, e.data, $time);
            end
        end
    endtask

    // Monitor: every ack/strobe seen at a requester must match the queue head.
    always @(negedge clk) begin
        if (ack_p0) sb_check(1'b0, K_ACK, 32'd0);
        if (ack_p1) sb_check(1'b1, K_ACK, 32'd0);
        if (strr_p0) begin
            sb_check(1'b0, K_STRR, dbr_p0);
            chk("dbr_p1_idle", dbr_p1, 32'd0);
        end
        if (strr_p1) begin
            sb_check(1'b1, K_STRR, dbr_p1);
            chk("dbr_p0_idle", dbr_p0, 32'd0);
        end
    end

    task automatic tk();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req0 = 0; wr0 = 0; adrs0 = 0; len0 = 0; be0 = 0; dbw0 = 0;
        req1 = 0; wr1 = 0; adrs1 = 0; len1 = 0; be1 = 0; dbw1 = 0;
        ack_m = 0; strr_m = 0; dbr_m = 0; auto_ack = 0;
        fx_req0 = 0; fx_req1 = 0;
    endtask

    task automatic do_reset(input bit check);
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        if (check) begin
            chk("rst_gnt", {30'd0, gnt}, 32'd0);
            chk("rst_err", {31'd0, err}, 32'd0);
            chk("rst_req_m", {31'd0, m_req}, 32'd0);
            chk("rst_acks", {28'd0, ack_p0, ack_p1, strr_p0, strr_p1}, 32'd0);
        end
        tk();
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int c1;

        // Reset state
        do_reset(1'b1);

        // p0 write len=3, ack every cycle
        req0 = 1; wr0 = 1; len0 = 3'd3; be0 = 4'hF; adrs0 = 32'h0000_1000; dbw0 = 32'h1111_0000;
        tk();
        ack_m = 1;
        repeat (4) push(1'b0, K_ACK, 32'd0);
        @(negedge clk);
        chk("wr_gnt", {30'd0, gnt}, 32'd1);
        chk("wr_adrs", m_adrs, 32'h0000_1000);
        chk("wr_len", {29'd0, m_len}, 32'd3);
        chk("wr_be", {28'd0, m_be}, 32'hF);
        chk("wr_dbw0", m_dbw, 32'h1111_0000);
        for (int b = 1; b < 4; b++) begin
            tk();
            dbw0 = 32'h1111_0000 + b;
            @(negedge clk);
            chk("wr_dbw", m_dbw, 32'h1111_0000 + b);
            chk("wr_gnt_hold", {30'd0, gnt}, 32'd1);
        end
        tk();
        ack_m = 0; req0 = 0;
        @(negedge clk);
        chk("wr_end_gnt", {30'd0, gnt}, 32'd0);

        // Both read len=0 together: p0 first, then p1 after a bubble
        do_reset(1'b0);
        req0 = 1; req1 = 1; wr0 = 0; wr1 = 0; len0 = 0; len1 = 0;
        adrs0 = 32'h0000_2000; adrs1 = 32'h0000_3000;
        tk();
        push(1'b0, K_ACK, 32'd0);
        push(1'b0, K_STRR, 32'h5A5A_0000);
        ack_m = 1;
        @(negedge clk);
        chk("rd_gnt0", {30'd0, gnt}, 32'd1);
        chk("rd_adrs0", m_adrs, 32'h0000_2000);
        tk();
        ack_m = 0; req0 = 0; strr_m = 1; dbr_m = 32'h5A5A_0000;
        @(negedge clk);
        chk("rd_wait_gnt0", {30'd0, gnt}, 32'd1);
        tk();
        strr_m = 0; dbr_m = 0;
        @(negedge clk);
        chk("rd_bubble", {30'd0, gnt}, 32'd0);
        tk();
        push(1'b1, K_ACK, 32'd0);
        push(1'b1, K_STRR, 32'hA5A5_0001);
        ack_m = 1;
        @(negedge clk);
        chk("rd_gnt1", {30'd0, gnt}, 32'd2);
        chk("rd_adrs1", m_adrs, 32'h0000_3000);
        tk();
        ack_m = 0; req1 = 0; strr_m = 1; dbr_m = 32'hA5A5_0001;
        tk();
        strr_m = 0; dbr_m = 0;
        @(negedge clk);
        chk("rd_end_gnt", {30'd0, gnt}, 32'd0);

        // Continuous requests: round-robin alternates, fixed priority starves p1
        do_reset(1'b0);
        wr0 = 1; wr1 = 1; len0 = 0; len1 = 0;
        req0 = 1; req1 = 1; fx_req0 = 1; fx_req1 = 1; auto_ack = 1;
        for (int i = 0; i < 10; i++) push(i[0], K_ACK, 32'd0);
        c0 = 0; c1 = 0;
        for (int i = 0; i < 20; i++) begin
            tk();
            @(negedge clk);
            if (fx_ack_p0) c0 = c0 + 1;
            if (fx_ack_p1) c1 = c1 + 1;
        end
        req0 = 0; req1 = 0; fx_req0 = 0; fx_req1 = 0; auto_ack = 0;
        chk("fix_p0_bursts", c0, 32'd10);
        chk("fix_p1_starved", c1, 32'd0);

        // Read len=7, strobes stop after 3: timeout 16 cycles later
        do_reset(1'b0);
        req0 = 1; wr0 = 0; len0 = 3'd7; adrs0 = 32'h0000_4000;
        tk();
        ack_m = 1;
        push(1'b0, K_ACK, 32'd0);
        push(1'b0, K_STRR, 32'hD000_0001);
        push(1'b0, K_STRR, 32'hD000_0002);
        push(1'b0, K_STRR, 32'hD000_0003);
        @(negedge clk);
        chk("to_gnt", {30'd0, gnt}, 32'd1);
        tk();
        ack_m = 0; strr_m = 1; dbr_m = 32'hD000_0001;
        @(negedge clk);
        chk("to_req_m_forced", {31'd0, m_req}, 32'd0);
        tk();
        req0 = 0; dbr_m = 32'hD000_0002;
        tk();
        dbr_m = 32'hD000_0003;
        tk();
        strr_m = 0; dbr_m = 0;
        repeat (15) tk();
        @(negedge clk);
        chk("to_err_before", {31'd0, err}, 32'd0);
        chk("to_gnt_before", {30'd0, gnt}, 32'd1);
        tk();
        @(negedge clk);
        chk("to_err", {31'd0, err}, 32'd1);
        chk("to_gnt_after", {30'd0, gnt}, 32'd0);

        // Ack and stray strobe while IDLE
        do_reset(1'b0);
        ack_m = 1;
        @(negedge clk);
        tk();
        ack_m = 0;
        @(negedge clk);
        chk("idle_ack_gnt", {30'd0, gnt}, 32'd0);
        chk("idle_ack_err", {31'd0, err}, 32'd0);
        tk();
        strr_m = 1; dbr_m = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("stray_strr_out", {30'd0, strr_p0, strr_p1}, 32'd0);
        tk();
        strr_m = 0; dbr_m = 0;
        @(negedge clk);
        chk("stray_err", {31'd0, err}, 32'd1);
        repeat (3) tk();
        chk("stray_err_sticky", {31'd0, err}, 32'd1);

        // Async reset in the middle of a write burst
        do_reset(1'b0);
        req0 = 1; wr0 = 1; len0 = 3'd3; be0 = 4'h5; adrs0 = 32'h0000_5000; dbw0 = 32'h7777_0000;
        tk();
        ack_m = 1;
        push(1'b0, K_ACK, 32'd0);
        push(1'b0, K_ACK, 32'd0);
        tk();
        tk();
        #1 rst_n = 1'b0;
        #1;
        chk("ar_gnt", {30'd0, gnt}, 32'd0);
        chk("ar_master", {24'd0, m_req, m_wr, m_len, m_be[2:0]}, 32'd0);
        chk("ar_adrs", m_adrs, 32'd0);
        chk("ar_dbw", m_dbw, 32'd0);
        chk("ar_ack", {30'd0, ack_p0, ack_p1}, 32'd0);
        chk("ar_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        clear_inputs();
        tk();
        rst_n = 1'b1;
        repeat (2) tk();

        chk("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
